// File: rtl/accum_sequencer.sv
// Front-end sequencer for the nibble-serial accumulator: parallel operands in, LSB-nibble-first issue, parallel result out.
// Optional feature macro ACC_SEQ_UNDERRUN_CNT_EN adds a saturating count of injected zero operands.
module accum_sequencer #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [BIT_WIDTH-1:0] op_data,
  input  logic                 op_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BIT_WIDTH-1:0] res_data,
  output logic                 busy,
  output logic                 acc_start,
  output logic [3:0]           acc_data_in,
  input  logic [3:0]           acc_data_out,
  input  logic                 acc_data_out_valid,
  input  logic                 acc_result_complete,
  input  logic                 acc_ready
`ifdef ACC_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_cnt
`endif
);

  localparam int N  = BIT_WIDTH / 4;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(N - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    FLUSH   = 2'd0,
    IDLE    = 2'd1,
    ISSUE   = 2'd2,
    COLLECT = 2'd3
  } state_t;

  state_t               state_r;
  logic [BIT_WIDTH-1:0] shift_r;
  logic                 shift_last_r;
  logic [BIT_WIDTH-1:0] pf_r;
  logic                 pf_last_r;
  logic                 pf_valid_r;
  logic [CW-1:0]        cnt_r;
  logic                 flush_seen_r;

  logic                 res_free_s;
  logic                 boundary_s;
  logic                 idle_go_s;
  logic                 start_job_s;
  logic                 load_s;
  logic                 pf_move_s;
  logic                 op_ready_s;
  logic                 op_fire_s;
  logic                 direct_s;
  logic [BIT_WIDTH-1:0] src_data_s;
  logic                 src_last_s;

  // Handshake decode and selection of the next operand source (prefetch first, then op_data, else zero).
  always_comb begin
    res_free_s  = !res_valid || res_ready;
    boundary_s  = (state_r == ISSUE) && (cnt_r == LAST_IDX) && !shift_last_r;
    idle_go_s   = (state_r == IDLE) && acc_ready && res_free_s;
    start_job_s = idle_go_s && (pf_valid_r || op_valid);
    load_s      = start_job_s || boundary_s;
    pf_move_s   = pf_valid_r && (idle_go_s || boundary_s);
    op_ready_s  = (state_r != FLUSH) && (!pf_valid_r || pf_move_s);
    op_fire_s   = op_valid && op_ready_s;
    direct_s    = load_s && !pf_valid_r && op_valid;
    if (pf_valid_r) begin
      src_data_s = pf_r;
      src_last_s = pf_last_r;
    end else if (op_valid) begin
      src_data_s = op_data;
      src_last_s = op_last;
    end else begin
      src_data_s = {BIT_WIDTH{1'b0}};
      src_last_s = 1'b0;
    end
  end

  assign op_ready = op_ready_s;

  // Sequencer FSM, operand buffers and all registered accumulator/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FLUSH;
      shift_r      <= {BIT_WIDTH{1'b0}};
      shift_last_r <= 1'b0;
      pf_r         <= {BIT_WIDTH{1'b0}};
      pf_last_r    <= 1'b0;
      pf_valid_r   <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      flush_seen_r <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= {BIT_WIDTH{1'b0}};
      busy         <= 1'b0;
      acc_start    <= 1'b0;
      acc_data_in  <= 4'h0;
    end else begin
      if (op_fire_s && !direct_s) begin
        pf_r       <= op_data;
        pf_last_r  <= op_last;
        pf_valid_r <= 1'b1;
      end else if (pf_move_s) begin
        pf_valid_r <= 1'b0;
      end else begin
        pf_valid_r <= pf_valid_r;
      end

      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state_r)
        FLUSH: begin
          busy        <= 1'b1;
          acc_data_in <= 4'h0;
          // Only output that answers our own start stream proves the accumulator is aligned to us.
          if (acc_result_complete && flush_seen_r) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            acc_start    <= 1'b0;
            flush_seen_r <= 1'b0;
          end else if (flush_seen_r || (acc_start && acc_data_out_valid)) begin
            flush_seen_r <= 1'b1;
            acc_start    <= 1'b0;
          end else begin
            acc_start <= 1'b1;
          end
        end
        IDLE: begin
          if (start_job_s) begin
            shift_r      <= {4'h0, src_data_s[BIT_WIDTH-1:4]};
            shift_last_r <= src_last_s;
            acc_data_in  <= src_data_s[3:0];
            acc_start    <= 1'b1;
            cnt_r        <= {CW{1'b0}};
            res_data     <= {BIT_WIDTH{1'b0}};
            state_r      <= ISSUE;
            busy         <= 1'b1;
          end else begin
            acc_start   <= 1'b0;
            acc_data_in <= 4'h0;
            busy        <= 1'b0;
          end
        end
        ISSUE: begin
          busy <= 1'b1;
          if (cnt_r != LAST_IDX) begin
            acc_data_in <= shift_r[3:0];
            shift_r     <= {4'h0, shift_r[BIT_WIDTH-1:4]};
            acc_start   <= shift_last_r && (cnt_r == PEN_IDX);
            cnt_r       <= cnt_r + CNT_ONE;
          end else if (shift_last_r) begin
            state_r     <= COLLECT;
            acc_start   <= 1'b0;
            acc_data_in <= 4'h0;
            cnt_r       <= {CW{1'b0}};
          end else begin
            shift_r      <= {4'h0, src_data_s[BIT_WIDTH-1:4]};
            shift_last_r <= src_last_s;
            acc_data_in  <= src_data_s[3:0];
            acc_start    <= 1'b0;
            cnt_r        <= {CW{1'b0}};
          end
        end
        COLLECT: begin
          busy        <= 1'b1;
          acc_start   <= 1'b0;
          acc_data_in <= 4'h0;
          if (acc_data_out_valid) begin
            res_data[4*cnt_r +: 4] <= acc_data_out;
            cnt_r                  <= cnt_r + CNT_ONE;
          end
          if (acc_result_complete) begin
            res_valid <= 1'b1;
            state_r   <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= FLUSH;
          acc_start <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

`ifdef ACC_SEQ_UNDERRUN_CNT_EN
  logic underrun_s;
  assign underrun_s = boundary_s && !pf_valid_r && !op_valid;

  // Saturating count of zero operands injected at operand boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= 16'h0000;
    end else if (underrun_s && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'h0001;
    end else begin
      underrun_cnt <= underrun_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer with a behavioural nibble-serial accumulator and a sum-of-operands reference.
module tb_accum_sequencer;

  localparam int BW = 32;
  localparam int N  = BW / 4;

  logic          clk, rst;
  logic          op_valid, op_ready, op_last;
  logic [BW-1:0] op_data;
  logic          res_valid, res_ready;
  logic [BW-1:0] res_data;
  logic          busy, acc_start;
  logic [3:0]    acc_data_in, acc_data_out;
  logic          acc_data_out_valid, acc_result_complete, acc_ready;
`ifdef ACC_SEQ_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  accum_sequencer #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_last(op_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .acc_start(acc_start), .acc_data_in(acc_data_in),
    .acc_data_out(acc_data_out), .acc_data_out_valid(acc_data_out_valid),
    .acc_result_complete(acc_result_complete), .acc_ready(acc_ready)
`ifdef ACC_SEQ_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [BW-1:0] exp_q[$];
  logic          rr_en = 1'b1;
  int            rr_pct = 100;
  logic [BW-1:0] job_ops[8];
  int            job_gap[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural accumulator: no reset, adds N-nibble operands, returns the sum nibble-serially.
  int            m_mode = 0;
  int            m_k = 0, m_r = 0, m_nib = 0, m_scnt = 0, m_slast = 0;
  logic [BW-1:0] m_cur = '0, m_sum = '0;
  int            last_nibs = 0, last_scnt = 0, last_slast = 0;
  logic [3:0]    m_dout = 4'h0;
  logic          m_valid = 1'b0, m_complete = 1'b0;

  assign acc_data_out        = m_dout;
  assign acc_data_out_valid  = m_valid;
  assign acc_result_complete = m_complete;
  assign acc_ready           = (m_mode == 0);

  always @(posedge clk) begin
    m_valid    <= 1'b0;
    m_complete <= 1'b0;
    m_dout     <= 4'h0;
    case (m_mode)
      0: if (acc_start) begin
        m_mode <= 1; m_cur <= {28'd0, acc_data_in}; m_k <= 1; m_sum <= '0;
        m_nib <= 1; m_scnt <= 1; m_slast <= 0;
      end
      1: begin
        m_nib <= m_nib + 1;
        if (acc_start) begin
          m_scnt <= m_scnt + 1; m_slast <= m_nib;
        end
        if (m_k == N - 1) begin
          m_sum <= m_sum + (m_cur | ({28'd0, acc_data_in} << (4 * (N - 1))));
          m_cur <= '0; m_k <= 0;
          if (acc_start) begin
            m_mode <= 2; m_r <= 0;
            last_nibs <= m_nib + 1; last_scnt <= m_scnt + 1; last_slast <= m_nib;
          end
        end else begin
          m_cur <= m_cur | ({28'd0, acc_data_in} << (4 * m_k));
          m_k <= m_k + 1;
        end
      end
      2: begin
        m_valid <= 1'b1;
        m_dout  <= m_sum[4*m_r +: 4];
        if (m_r == N - 1) m_mode <= 3;
        else m_r <= m_r + 1;
      end
      default: begin
        m_complete <= 1'b1;
        m_mode <= 0;
      end
    endcase
  end

  // Result consumer: random backpressure, every handshake compared against the reference queue.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      res_ready = rr_en && ($urandom_range(99) < rr_pct);
      #1;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check_eq("res_extra", 32'(exp_q.size()), 32'd1);
        else check_eq("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  task automatic push_op(input logic [BW-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    op_valid = 1'b1; op_data = d; op_last = l;
    #1;
    while (!op_ready && t < 2000) begin
      @(negedge clk); #1; t++;
    end
    if (!op_ready) check_eq("op_accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
  endtask

  task automatic run_job(input int n);
    logic [BW-1:0] sum = '0;
    for (int i = 0; i < n; i++) sum = sum + job_ops[i];
    exp_q.push_back(sum);
    for (int i = 0; i < n; i++) begin
      if (job_gap[i] > 0) begin
        @(negedge clk); op_valid = 1'b0;
        repeat (job_gap[i] - 1) @(negedge clk);
      end
      push_op(job_ops[i], (i == n - 1));
    end
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); t++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_flush_done();
    int t = 0;
    @(negedge clk); #1;
    while (busy && t < 500) begin
      @(negedge clk); #1; t++;
    end
    check_eq("flush_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_res_valid();
    int t = 0;
    @(negedge clk); #1;
    while (!res_valid && t < 500) begin
      @(negedge clk); #1; t++;
    end
    check_eq("res_valid_rise", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int ops);
    check_eq({tag, "_nibs"}, 32'(last_nibs), 32'(ops * N));
    check_eq({tag, "_starts"}, 32'(last_scnt), 32'd2);
    check_eq({tag, "_last_start"}, 32'(last_slast), 32'(ops * N - 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] held;
    int bad, starts;
    int uc0;
    rst = 1'b1; op_valid = 1'b0; op_data = '0; op_last = 1'b0;
    for (int i = 0; i < 8; i++) job_gap[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_op_ready", {31'd0, op_ready}, 32'd0);
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_acc_start", {31'd0, acc_start}, 32'd0);
    check_eq("rst_acc_data_in", {28'd0, acc_data_in}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check_eq("busy_in_flush", {31'd0, busy}, 32'd1);
    wait_flush_done();

    // Single operand, result held under backpressure.
    rr_en = 1'b0;
    job_ops[0] = 32'h0000_0005;
    run_job(1);
    wait_res_valid();
    repeat (5) @(negedge clk);
    #1;
    check_eq("held_valid", {31'd0, res_valid}, 32'd1);
    check_eq("held_data", res_data, 32'h0000_0005);
    check_frame("single", 1);
    rr_en = 1'b1;
    drain();
    @(negedge clk); #1;
    check_eq("res_valid_cleared", {31'd0, res_valid}, 32'd0);

    // Back-to-back operands, gap-free issue.
    job_ops[0] = 32'h1234_5678; job_ops[1] = 32'h1111_1111; job_ops[2] = 32'h0000_0001;
    run_job(3);
    drain();
    check_frame("b2b", 3);

    // Wrap modulo 2^32.
    job_ops[0] = 32'hFFFF_FFFF; job_ops[1] = 32'h0000_0001;
    run_job(2);
    drain();
    check_frame("wrap", 2);

    // Underrun: second operand late, one zero operand injected.
`ifdef ACC_SEQ_UNDERRUN_CNT_EN
    uc0 = int'(underrun_cnt);
`else
    uc0 = 0;
`endif
    job_ops[0] = 32'd3; job_ops[1] = 32'd4; job_gap[1] = 10;
    run_job(2);
    job_gap[1] = 0;
    drain();
    check_frame("underrun", 3);
`ifdef ACC_SEQ_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", 32'(int'(underrun_cnt) - uc0), 32'd1);
`endif

    // Result not consumed with the next operand waiting: no new job may open.
    rr_en = 1'b0;
    job_ops[0] = 32'hCAFE_0001;
    run_job(1);
    job_ops[0] = 32'h0000_0042;
    run_job(1);
    wait_res_valid();
    held = res_data;
    check_eq("hold_first", held, 32'hCAFE_0001);
    bad = 0; starts = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (!res_valid || res_data !== held) bad++;
      if (acc_start) starts++;
    end
    check_eq("hold_stable", 32'(bad), 32'd0);
    check_eq("hold_no_start", 32'(starts), 32'd0);
    rr_en = 1'b1;
    drain();

    // Reset in the middle of issue; the accumulator must be flushed.
    job_ops[0] = 32'h1111_1111;
    push_op(job_ops[0], 1'b0);
    @(negedge clk); op_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_acc_start", {31'd0, acc_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_flush_done();
    job_ops[0] = 32'h0000_000A;
    run_job(1);
    drain();
    check_frame("after_rst", 1);

    // Randomised jobs with random gaps and random result backpressure.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(4, 1);
      rr_pct = $urandom_range(100, 20);
      for (int i = 0; i < n; i++) begin
        job_ops[i] = $urandom;
        job_gap[i] = ($urandom_range(99) < 70) ? 0 : $urandom_range(14, 1);
      end
      run_job(n);
    end
    rr_pct = 100;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Front-end controller for the nibble-serial accumulator.
- Accepts parallel BIT_WIDTH operands over a valid/ready stream, serialises them LSB-nibble-first onto the accumulator's start/data_in protocol, and reassembles the nibble-serial result into a parallel result word.
- Owns job framing, gap-free operand issue, result capture, and recovery of an un-reset accumulator after sequencer reset.

Parameters:
- BIT_WIDTH, 32, operand and result width in bits; multiple of 4, at least 8. N = BIT_WIDTH/4 nibbles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  operand available
- op_ready  out  1  operand accepted when op_valid and op_ready are both high
- op_data  in  BIT_WIDTH  operand
- op_last  in  1  operand is the last of the job
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid and res_ready are both high
- res_data  out  BIT_WIDTH  sum modulo 2^BIT_WIDTH
- busy  out  1  high in every state except IDLE
- acc_start  out  1  to accumulator start
- acc_data_in  out  4  to accumulator data_in
- acc_data_out  in  4  from accumulator
- acc_data_out_valid  in  1  from accumulator
- acc_result_complete  in  1  from accumulator
- acc_ready  in  1  from accumulator

Behaviour:
- Reset values: all outputs 0 (op_ready, res_valid, res_data, busy, acc_start, acc_data_in); state FLUSH; buffers empty.
- Reset is asynchronous; it may arrive mid-job. The accumulator has no reset, so the sequencer always leaves reset through FLUSH.
- acc_start and acc_data_in are registered.
- Accumulator protocol:
  - A job opens with acc_start=1 on nibble 0 of the first operand.
  - Every operand is N consecutive nibbles, LSB first, with no idle cycles between operands inside a job.
  - acc_start=1 on nibble N-1 marks the final operand.
  - The accumulator then returns N nibbles, LSB first, with acc_data_out_valid=1, followed by an acc_result_complete pulse.
- Buffering: one shift register (current operand) plus one prefetch register.
  - op_ready = prefetch empty, or prefetch moving to the shift register this cycle.
  - The shift register loads from prefetch, or from op_data directly when prefetch is empty.
- States:
  - FLUSH:
    - Drive acc_start=1, acc_data_in=0 until acc_data_out_valid is seen; then acc_start=0.
    - Discard all returned nibbles.
    - On acc_result_complete, go to IDLE.
  - IDLE:
    - Wait for op_valid && acc_ready && !res_valid.
    - Then load the operand, clear res_data, and go to ISSUE.
  - ISSUE:
    - Drive nibble i of the shift register with a 0..N-1 counter.
    - acc_start = (i==0 && first operand of job) || (i==N-1 && current op_last).
    - At i==N-1 with last: go to COLLECT.
    - At i==N-1 otherwise: load the next operand in the following cycle.
    - Underrun (no operand in prefetch or on op_data at i==N-1): load a zero operand with last=0, which adds nothing to the sum. Repeat each N-cycle boundary until a real operand arrives.
  - COLLECT:
    - acc_start=0.
    - On each acc_data_out_valid, write acc_data_out into res_data nibble j (j = 0..N-1).
    - On acc_result_complete: set res_valid, go to IDLE.
- Result: res_valid holds until res_ready; res_data stays stable while res_valid=1. A new job cannot open while res_valid=1.
- Simultaneous events:
  - A res_ready handshake in the same cycle as the IDLE start check counts as res_valid=0.
  - op_valid during COLLECT fills prefetch only; that operand opens the next job.
- Single-operand job: acc_start is high on both nibble 0 and nibble N-1.
- Latency: first nibble reaches the accumulator 1 cycle after the IDLE accept. res_valid rises 1 cycle after acc_result_complete.

Optional Feature:
- Macro: ACC_SEQ_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt, 16 bits: saturating count of injected zero operands.
  - Reset value 0; never wraps (holds at 0xFFFF).
- Undefined:
  - Port and counter are absent.
  - Zero-operand injection behaves identically.

Test Plan:
- Reset, then single operand 0x00000005 with op_last=1 -> FLUSH completes; acc_start high on nibbles 0 and 7; res_data=0x00000005; res_valid held until res_ready.
- Back-to-back 0x12345678, 0x11111111, 0x00000001(last) -> 24 contiguous nibble cycles with no gap; res_data=0x2345678A.
- 0xFFFFFFFF then 0x00000001(last) -> res_data=0x00000000 (wrap).
- Operand 3, then 4(last) presented 10 cycles after the first accept -> one zero operand injected; res_data=7; underrun_cnt=1 with the macro defined.
- res_ready held low 20 cycles with the next operand waiting -> no acc_start until the result is consumed; res_data stable throughout.
- rst asserted mid-ISSUE, then released -> FLUSH drains the accumulator and discards its output; the next job 0xA(last) gives res_data=0x0000000A.
